// File: rtl/i2c_slave_responder_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit values and the default MPU6050 address.
// Also used by the on-chip I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        RX_PTR   = 4'd3,
        PTR_ACK  = 4'd4,
        RX_DATA  = 4'd5,
        DATA_ACK = 4'd6,
        TX_DATA  = 4'd7,
        TX_ACK   = 4'd8,
        IGNORE   = 4'd9
    } i2c_state_e;

    localparam logic       I2C_RW_WRITE  = 1'b0;
    localparam logic       I2C_RW_READ   = 1'b1;
    localparam logic [6:0] MPU6050_ADDR  = 7'h68;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    // Address phase byte is {addr[6:0], rw}; only the upper seven bits take part in matching.
    function automatic logic addr_match(input logic [7:0] rx_byte, input logic [6:0] addr);
        return (rx_byte[7:1] == addr);
    endfunction

endpackage

// File: rtl/i2c_slave_responder_line_sync.sv
// Two-flop synchronizer plus history flop for SCL/SDA, with registered edge pulses
// and START/STOP qualification (SDA edge while SCL is stably high).
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_level
);

    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;
    logic scl_rise_r, scl_fall_r, sda_rise_r, sda_fall_r;
    logic scl_high_r, sda_lvl_r;

    // Synchronize both lines and register edge pulses aligned with the sampled SDA level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            sda_rise_r <= 1'b0;
            sda_fall_r <= 1'b0;
            scl_high_r <= 1'b1;
            sda_lvl_r  <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
            scl_rise_r <= scl_sync_r & ~scl_hist_r;
            scl_fall_r <= ~scl_sync_r & scl_hist_r;
            sda_rise_r <= sda_sync_r & ~sda_hist_r;
            sda_fall_r <= ~sda_sync_r & sda_hist_r;
            scl_high_r <= scl_sync_r & scl_hist_r;
            sda_lvl_r  <= sda_sync_r;
        end
    end

    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start     = sda_fall_r & scl_high_r;
    assign stop      = sda_rise_r & scl_high_r;
    assign sda_level = sda_lvl_r;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with 7-bit address match, register pointer, auto-incrementing reads/writes
// through an external register port. SDA is open-drain: pulled low or released.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = MPU6050_ADDR,
    parameter int         ADDR_WIDTH    = 8,
    parameter int         AUTO_INC      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL_BUS,
    inout  wire                   SDA_BUS,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [7:0]            reg_rdata,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    output logic                  busy,
    output logic                  nack_seen
);

    localparam logic AUTO_INC_EN = (AUTO_INC != 0);

    i2c_state_e state_r;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s, sda_level_s;
    logic [6:0] shift_r;
    logic [6:0] tx_sr_r;
    logic [3:0] bit_cnt_r;
    logic       sda_low_r;
    logic       inc_pend_r;
    logic       ack_pend_r;
    logic [7:0] next_byte_s;
    logic       last_bit_s;
    logic       rx_bit_s;
    logic       byte_done_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (SCL_BUS),
        .sda_in    (SDA_BUS),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start     (start_s),
        .stop      (stop_s),
        .sda_level (sda_level_s)
    );

    assign SDA_BUS     = sda_low_r ? 1'b0 : 1'bz;
    assign next_byte_s = {shift_r, sda_level_s};
    assign rx_bit_s    = scl_rise_s && (bit_cnt_r < BITS_PER_BYTE);
    assign last_bit_s  = (bit_cnt_r == (BITS_PER_BYTE - 4'd1));
    assign byte_done_s = scl_fall_s && (bit_cnt_r == BITS_PER_BYTE);

    // Protocol FSM; START/STOP take priority over bit processing in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= 7'd0;
            tx_sr_r    <= 7'd0;
            bit_cnt_r  <= 4'd0;
            sda_low_r  <= 1'b0;
            inc_pend_r <= 1'b0;
            ack_pend_r <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= 8'd0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            nack_seen  <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            nack_seen <= 1'b0;
            // Pointer advance after a write lands one cycle after the reg_we strobe.
            if (inc_pend_r) begin
                reg_addr   <= reg_addr + ADDR_WIDTH'(1);
                inc_pend_r <= 1'b0;
            end
            if (start_s) begin
                state_r    <= ADDR;
                bit_cnt_r  <= 4'd0;
                shift_r    <= 7'd0;
                sda_low_r  <= 1'b0;
                ack_pend_r <= 1'b0;
            end else if (stop_s) begin
                state_r    <= IDLE;
                sda_low_r  <= 1'b0;
                busy       <= 1'b0;
                ack_pend_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sda_low_r <= 1'b0;
                    end
                    ADDR: begin
                        if (rx_bit_s) begin
                            shift_r   <= next_byte_s[6:0];
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (last_bit_s && !addr_match(next_byte_s, SLAVE_ADDRESS)) begin
                                state_r <= IGNORE;
                            end
                        end else if (byte_done_s) begin
                            sda_low_r <= 1'b1;
                            busy      <= 1'b1;
                            state_r   <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[0] == I2C_RW_READ) begin
                                reg_re    <= 1'b1;
                                sda_low_r <= ~reg_rdata[7];
                                tx_sr_r   <= reg_rdata[6:0];
                                state_r   <= TX_DATA;
                            end else begin
                                sda_low_r <= 1'b0;
                                state_r   <= RX_PTR;
                            end
                        end
                    end
                    RX_PTR: begin
                        if (rx_bit_s) begin
                            shift_r   <= next_byte_s[6:0];
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (last_bit_s) begin
                                reg_addr <= ADDR_WIDTH'(next_byte_s);
                            end
                        end else if (byte_done_s) begin
                            sda_low_r <= 1'b1;
                            state_r   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, DATA_ACK: begin
                        if (scl_fall_s) begin
                            sda_low_r <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_bit_s) begin
                            shift_r   <= next_byte_s[6:0];
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (last_bit_s) begin
                                reg_wdata  <= next_byte_s;
                                reg_we     <= 1'b1;
                                inc_pend_r <= AUTO_INC_EN;
                            end
                        end else if (byte_done_s) begin
                            sda_low_r <= 1'b1;
                            state_r   <= DATA_ACK;
                        end
                    end
                    TX_DATA: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (byte_done_s) begin
                            sda_low_r <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= TX_ACK;
                        end else if (scl_fall_s) begin
                            sda_low_r <= ~tx_sr_r[6];
                            tx_sr_r   <= {tx_sr_r[5:0], 1'b0};
                        end
                    end
                    TX_ACK: begin
                        // Pointer advances on the ACK clock; the next byte is fetched on the
                        // following fall so reg_rdata already reflects the new address.
                        if (scl_rise_s) begin
                            if (sda_level_s == 1'b0) begin
                                ack_pend_r <= 1'b1;
                                if (AUTO_INC_EN) begin
                                    reg_addr <= reg_addr + ADDR_WIDTH'(1);
                                end
                            end else begin
                                nack_seen <= 1'b1;
                                state_r   <= IGNORE;
                            end
                        end else if (scl_fall_s && ack_pend_r) begin
                            ack_pend_r <= 1'b0;
                            reg_re     <= 1'b1;
                            sda_low_r  <= ~reg_rdata[7];
                            tx_sr_r    <= reg_rdata[6:0];
                            bit_cnt_r  <= 4'd0;
                            state_r    <= TX_DATA;
                        end
                    end
                    IGNORE: begin
                        sda_low_r <= 1'b0;
                    end
                    default: begin
                        state_r   <= IDLE;
                        sda_low_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus-level I2C master drives directed transactions while a
// register-port model and an expectation scoreboard check strobes, ACKs and read data.
module tb_i2c_slave_responder;
    import i2c_pkg::*;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m_low;
    wire        sda_bus;
    logic [7:0] reg_addr, reg_rdata, reg_wdata;
    logic       reg_we, reg_re, busy, nack_seen;
    logic [7:0] mem [0:255];
    int         tests, failed, nack_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        exp_wq[$];
    logic [7:0] exp_rq[$];

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus   = sda_m_low ? 1'b0 : 1'bz;
    assign reg_rdata = mem[reg_addr];

    i2c_slave_responder dut (
        .clk       (clk),
        .reset     (reset),
        .SCL_BUS   (scl_m),
        .SDA_BUS   (sda_bus),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe checker: every reg_we/reg_re must match the next expected transfer.
    task automatic monitor();
        wr_t        w;
        logic [7:0] ra;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (reg_we) begin
                    if (exp_wq.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL we_unexpected: got write %02h at %02h, required no write", reg_wdata, reg_addr);
                    end else begin
                        w = exp_wq.pop_front();
                        chk("we_addr", reg_addr, w.a);
                        chk("we_data", reg_wdata, w.d);
                    end
                end
                if (reg_re) begin
                    if (exp_rq.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL re_unexpected: got read at %02h, required no read", reg_addr);
                    end else begin
                        ra = exp_rq.pop_front();
                        chk("re_addr", reg_addr, ra);
                    end
                end
                if (nack_seen) nack_cnt++;
            end
        end
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            wait_clk(2);
            sda_m_low = 1'b0;
            wait_clk(H - 2);
            scl_m = 1'b1;
        end else begin
            sda_m_low = 1'b0;
        end
        wait_clk(H);
        sda_m_low = 1'b1;
        wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(2);
        sda_m_low = 1'b1;
        wait_clk(H - 2);
        scl_m = 1'b1;
        wait_clk(H);
        sda_m_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(2);
        sda_m_low = ~b;
        wait_clk(H - 2);
        scl_m = 1'b1;
        wait_clk(H);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(2);
        sda_m_low = 1'b0;
        wait_clk(H - 2);
        scl_m = 1'b1;
        wait_clk(H - 1);
        b = sda_bus;
        wait_clk(1);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic nb;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(nb);
        ack = ~nb;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        write_bit(~ack);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wq.push_back(w);
        mem[a] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         n0;
        reset     = 1'b1;
        scl_m     = 1'b1;
        sda_m_low = 1'b0;
        tests     = 0;
        failed    = 0;
        nack_cnt  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h75] = 8'h68;
        mem[8'hFE] = 8'hC3;
        mem[8'hFF] = 8'h3C;
        mem[8'h00] = 8'h81;
        mem[8'h10] = 8'h00;
        wait_clk(4);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_flags", {4'd0, reg_we, reg_re, busy, nack_seen}, 8'h00);
        chk("rst_sda", {7'd0, sda_bus}, 8'h01);
        reset = 1'b0;
        wait_clk(4);
        fork
            monitor();
        join_none

        // Address mismatch: 7'h69 is ignored, including a following byte.
        i2c_start();
        send_byte(8'hD2, ack);
        chk("mismatch_ack", {7'd0, ack}, 8'h00);
        chk("mismatch_busy", {7'd0, busy}, 8'h00);
        send_byte(8'h11, ack);
        chk("ignore_ack", {7'd0, ack}, 8'h00);
        i2c_stop();
        wait_clk(4);
        chk("mismatch_busy_end", {7'd0, busy}, 8'h00);

        // Pointer 0x3B then two data bytes with auto-increment.
        i2c_start();
        send_byte(8'hD0, ack);
        chk("wr_addr_ack", {7'd0, ack}, 8'h01);
        chk("wr_busy", {7'd0, busy}, 8'h01);
        send_byte(8'h3B, ack);
        chk("wr_ptr_ack", {7'd0, ack}, 8'h01);
        chk("wr_ptr", reg_addr, 8'h3B);
        push_wr(8'h3B, 8'hA5);
        send_byte(8'hA5, ack);
        chk("wr_d0_ack", {7'd0, ack}, 8'h01);
        push_wr(8'h3C, 8'h5A);
        send_byte(8'h5A, ack);
        chk("wr_d1_ack", {7'd0, ack}, 8'h01);
        i2c_stop();
        wait_clk(4);
        chk("wr_busy_end", {7'd0, busy}, 8'h00);
        chk("wr_ptr_end", reg_addr, 8'h3D);
        chk("wr_all_seen", 8'(exp_wq.size()), 8'd0);

        // Pointer write, repeated START, single read with NACK.
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h75, ack);
        chk("rs_ptr_ack", {7'd0, ack}, 8'h01);
        i2c_start();
        exp_rq.push_back(8'h75);
        send_byte(8'hD1, ack);
        chk("rs_addr_ack", {7'd0, ack}, 8'h01);
        n0 = nack_cnt;
        recv_byte(rb, 1'b0);
        chk("rs_data_lit", rb, 8'h68);
        chk("rs_data_model", rb, mem[8'h75]);
        chk("rs_nack_pulse", 8'(nack_cnt - n0), 8'd1);
        chk("rs_busy", {7'd0, busy}, 8'h01);
        i2c_stop();
        wait_clk(4);
        chk("rs_busy_end", {7'd0, busy}, 8'h00);

        // Burst read across the pointer wrap.
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'hFE, ack);
        i2c_start();
        exp_rq.push_back(8'hFE);
        exp_rq.push_back(8'hFF);
        exp_rq.push_back(8'h00);
        send_byte(8'hD1, ack);
        chk("burst_addr_ack", {7'd0, ack}, 8'h01);
        n0 = nack_cnt;
        recv_byte(rb, 1'b1);
        chk("burst_b0", rb, 8'hC3);
        recv_byte(rb, 1'b1);
        chk("burst_b1", rb, 8'h3C);
        recv_byte(rb, 1'b0);
        chk("burst_b2", rb, mem[8'h00]);
        chk("burst_wrap_ptr", reg_addr, 8'h00);
        chk("burst_nack_pulse", 8'(nack_cnt - n0), 8'd1);
        i2c_stop();
        wait_clk(4);
        chk("burst_reads_seen", 8'(exp_rq.size()), 8'd0);

        // Reset while the slave holds SDA low for a 0 data bit.
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h10, ack);
        i2c_start();
        exp_rq.push_back(8'h10);
        send_byte(8'hD1, ack);
        wait_clk(6);
        chk("tx_sda_low", {7'd0, sda_bus}, 8'h00);
        reset = 1'b1;
        #1;
        chk("rst_async_sda", {7'd0, sda_bus}, 8'h01);
        chk("rst_async_addr", reg_addr, 8'h00);
        chk("rst_async_flags", {4'd0, reg_we, reg_re, busy, nack_seen}, 8'h00);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        chk("rst_reads_seen", 8'(exp_rq.size()), 8'd0);
        i2c_start();
        send_byte(8'hD0, ack);
        chk("post_rst_ack", {7'd0, ack}, 8'h01);
        send_byte(8'h20, ack);
        push_wr(8'h20, 8'h99);
        send_byte(8'h99, ack);
        chk("post_rst_data_ack", {7'd0, ack}, 8'h01);
        i2c_stop();
        wait_clk(4);
        chk("post_rst_ptr", reg_addr, 8'h21);

        // STOP in the middle of a data byte.
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h40, ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_stop();
        wait_clk(4);
        chk("midstop_busy", {7'd0, busy}, 8'h00);
        chk("midstop_ptr", reg_addr, 8'h40);
        chk("midstop_sda", {7'd0, sda_bus}, 8'h01);

        wait_clk(4);
        chk("final_writes_seen", 8'(exp_wq.size()), 8'd0);
        chk("final_reads_seen", 8'(exp_rq.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
